vc_packetizer: RTL and testbench

//  Sending-bundle stage directly downstream of the per-destination VC lookup shim.

---
 rtl/vc_packetizer.sv | 161 ++++++++++++++++
 tb/tb_vc_packetizer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/vc_packetizer.sv
// Splits a wide message into NUM_FLITS router flits on the VC returned by the lookup shim, gated by per-VC credits.
// Optional credit-overflow detection is built when VC_PACKETIZER_ERR_EN is defined.
module vc_packetizer #(
  parameter int N_ADDR_WIDTH  = 4,
  parameter int VC_ADDR_WIDTH = 2,
  parameter int FLIT_WIDTH    = 36,
  parameter int NUM_FLITS     = 4,
  parameter int CREDITS       = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             msg_valid,
  output logic                             msg_ready,
  input  logic [FLIT_WIDTH*NUM_FLITS-1:0]  msg_data,
  input  logic [N_ADDR_WIDTH-1:0]          msg_dest,
  output logic [N_ADDR_WIDTH-1:0]          lut_dest,
  input  logic [VC_ADDR_WIDTH-1:0]         lut_vc,
  output logic                             flit_valid,
  output logic                             flit_head,
  output logic                             flit_tail,
  output logic [VC_ADDR_WIDTH-1:0]         flit_vc,
  output logic [N_ADDR_WIDTH-1:0]          flit_dest,
  output logic [FLIT_WIDTH-1:0]            flit_data,
  input  logic [(2**VC_ADDR_WIDTH)-1:0]    credit_in,
  output logic                             error
);

  localparam int NUM_VC    = 2**VC_ADDR_WIDTH;
  localparam int MSG_WIDTH = FLIT_WIDTH*NUM_FLITS;
  localparam int CNT_WIDTH = $clog2(CREDITS+1);
  localparam int IDX_WIDTH = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                   state_reg, state_next;
  logic [MSG_WIDTH-1:0]     data_reg;
  logic [N_ADDR_WIDTH-1:0]  dest_reg;
  logic [VC_ADDR_WIDTH-1:0] vc_reg;
  logic [IDX_WIDTH-1:0]     idx_reg;
  logic [FLIT_WIDTH-1:0]    slice [NUM_FLITS];
  logic [CNT_WIDTH-1:0]     credit_cnt [NUM_VC];
  logic                     accept, issue, is_last;

  logic                     flit_valid_reg, flit_head_reg, flit_tail_reg;
  logic [VC_ADDR_WIDTH-1:0] flit_vc_reg;
  logic [N_ADDR_WIDTH-1:0]  flit_dest_reg;
  logic [FLIT_WIDTH-1:0]    flit_data_reg;

  assign msg_ready = (state_reg == IDLE);
  assign lut_dest  = msg_dest;
  assign accept    = msg_ready && msg_valid;
  assign is_last   = (idx_reg == IDX_WIDTH'(NUM_FLITS-1));

  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    case (state_reg)
      IDLE: if (msg_valid) state_next = SEND;
      SEND: begin
        if (credit_cnt[vc_reg] != '0) begin
          issue = 1'b1;
          if (is_last) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FLITS; gi++) begin : g_slice
      assign slice[gi] = data_reg[gi*FLIT_WIDTH +: FLIT_WIDTH];
    end
  endgenerate

`ifdef VC_PACKETIZER_ERR_EN
  logic [NUM_VC-1:0] overflow;
  logic              error_reg;
`endif

  // A returned credit only lands in the counter at the edge, so it is usable the cycle after.
  generate
    for (gi = 0; gi < NUM_VC; gi++) begin : g_credit
      logic [CNT_WIDTH-1:0] cnt_reg;
      logic                 dec, full;
      assign dec  = issue && (vc_reg == VC_ADDR_WIDTH'(gi));
      assign full = (cnt_reg == CNT_WIDTH'(CREDITS));
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= CNT_WIDTH'(CREDITS);
        end else if (credit_in[gi] && !dec && !full) begin
          cnt_reg <= cnt_reg + CNT_WIDTH'(1);
        end else if (dec && !credit_in[gi]) begin
          cnt_reg <= cnt_reg - CNT_WIDTH'(1);
        end
      end
      assign credit_cnt[gi] = cnt_reg;
`ifdef VC_PACKETIZER_ERR_EN
      assign overflow[gi] = credit_in[gi] && !dec && full;
`endif
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      data_reg  <= '0;
      dest_reg  <= '0;
      vc_reg    <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        data_reg <= msg_data;
        dest_reg <= msg_dest;
        vc_reg   <= lut_vc;
        idx_reg  <= '0;
      end else if (issue) begin
        idx_reg <= idx_reg + IDX_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flit_valid_reg <= 1'b0;
      flit_head_reg  <= 1'b0;
      flit_tail_reg  <= 1'b0;
      flit_vc_reg    <= '0;
      flit_dest_reg  <= '0;
      flit_data_reg  <= '0;
    end else begin
      flit_valid_reg <= issue;
      if (issue) begin
        flit_head_reg <= (idx_reg == '0);
        flit_tail_reg <= is_last;
        flit_vc_reg   <= vc_reg;
        flit_dest_reg <= dest_reg;
        flit_data_reg <= slice[idx_reg];
      end
    end
  end

  assign flit_valid = flit_valid_reg;
  assign flit_head  = flit_head_reg;
  assign flit_tail  = flit_tail_reg;
  assign flit_vc    = flit_vc_reg;
  assign flit_dest  = flit_dest_reg;
  assign flit_data  = flit_data_reg;

`ifdef VC_PACKETIZER_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) error_reg <= 1'b0;
    else        error_reg <= error_reg | (|overflow);
  end
  assign error = error_reg;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_vc_packetizer.sv
// Directed bench for vc_packetizer (NUM_FLITS=4, CREDITS=8): flit sequencing, credit stalls, reset abort, overflow.
module tb_vc_packetizer;
  localparam int NA    = 4;
  localparam int VW    = 2;
  localparam int FW    = 36;
  localparam int NF    = 4;
  localparam int CR    = 8;
  localparam int MSG_W = FW*NF;
`ifdef VC_PACKETIZER_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             msg_valid = 1'b0;
  logic             msg_ready;
  logic [MSG_W-1:0] msg_data = '0;
  logic [NA-1:0]    msg_dest = '0;
  logic [NA-1:0]    lut_dest;
  logic [VW-1:0]    lut_vc = '0;
  logic             flit_valid, flit_head, flit_tail;
  logic [VW-1:0]    flit_vc;
  logic [NA-1:0]    flit_dest;
  logic [FW-1:0]    flit_data;
  logic [3:0]       credit_in = '0;
  logic             error;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vc_packetizer #(
    .N_ADDR_WIDTH(NA), .VC_ADDR_WIDTH(VW), .FLIT_WIDTH(FW), .NUM_FLITS(NF), .CREDITS(CR)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data), .msg_dest(msg_dest),
    .lut_dest(lut_dest), .lut_vc(lut_vc),
    .flit_valid(flit_valid), .flit_head(flit_head), .flit_tail(flit_tail),
    .flit_vc(flit_vc), .flit_dest(flit_dest), .flit_data(flit_data),
    .credit_in(credit_in), .error(error)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MSG_W-1:0] make_msg(input logic [FW-1:0] base);
    logic [MSG_W-1:0] m;
    m = '0;
    for (int i = 0; i < NF; i++) m[i*FW +: FW] = base + FW'(i);
    return m;
  endfunction

  // Packed as {valid, head, tail, vc, dest, data}.
  task automatic expect_flit(input string tag, input int idx, input logic [VW-1:0] vc,
                             input logic [NA-1:0] dest, input logic [FW-1:0] base);
    logic [44:0] exp;
    exp = {1'b1, idx == 0, idx == NF-1, vc, dest, base + FW'(idx)};
    check($sformatf("%s_flit%0d", tag, idx),
          {flit_valid, flit_head, flit_tail, flit_vc, flit_dest, flit_data}, exp);
  endtask

  // Offers one message; returns in the first SEND cycle with the shim inputs scrambled.
  task automatic accept(input string tag, input logic [NA-1:0] dest, input logic [VW-1:0] vc,
                        input logic [FW-1:0] base);
    int n;
    n = 0;
    while (msg_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, msg_ready, 1'b1);
    msg_valid = 1'b1;
    msg_dest  = dest;
    lut_vc    = vc;
    msg_data  = make_msg(base);
    #1;
    check({tag, "_lut_dest"}, lut_dest, dest);
    tick();
    msg_valid = 1'b0;
    msg_dest  = ~dest;
    lut_vc    = ~vc;
    check({tag, "_busy"}, {msg_ready, flit_valid}, 2'b00);
  endtask

  task automatic run_packet(input string tag, input logic [NA-1:0] dest, input logic [VW-1:0] vc,
                            input logic [FW-1:0] base);
    accept(tag, dest, vc, base);
    for (int i = 0; i < NF; i++) begin
      tick();
      expect_flit(tag, i, vc, dest, base);
      check($sformatf("%s_ready%0d", tag, i), msg_ready, (i == NF-1));
    end
    $display("packet %s dest=%0d vc=%0d base=%0h done", tag, dest, vc, base);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_flit", {flit_valid, flit_head, flit_tail, flit_vc, flit_dest, flit_data}, '0);
    check("rst_ready_err", {msg_ready, error}, 2'b10);
    rst_n = 1'b1;
    tick();

    // Basic packet: dest 3, VC2, flits 1..4
    run_packet("t1", 4'd3, 2'd2, 36'h1);
    tick();
    check("t1_after_tail", flit_valid, 1'b0);

    // Drain VC0 to zero, then VC1 still streams freely; finally drain VC1 as well
    run_packet("t3_vc0a", 4'd5, 2'd0, 36'h10);
    run_packet("t3_vc0b", 4'd5, 2'd0, 36'h20);
    run_packet("t3_vc1a", 4'd6, 2'd1, 36'h30);
    run_packet("t3_vc1b", 4'd6, 2'd1, 36'h40);
    tick();
    credit_in = 4'b0001; tick();
    credit_in = 4'b0001; tick();
    credit_in = 4'b0010; tick();
    credit_in = 4'b0010; tick();
    credit_in = 4'b0000;

    // VC1 holds 2 credits: 2 flits, stall, then released by returns
    accept("t2", 4'd7, 2'd1, 36'h50);
    tick(); expect_flit("t2", 0, 2'd1, 4'd7, 36'h50);
    tick(); expect_flit("t2", 1, 2'd1, 4'd7, 36'h50);
    tick(); check("t2_stall_a", flit_valid, 1'b0);
    tick(); check("t2_stall_b", flit_valid, 1'b0);
    credit_in = 4'b0010;
    tick(); check("t2_no_same_cycle_use", flit_valid, 1'b0);
    credit_in = 4'b0010;   // return coincides with the issue of flit 2
    tick(); credit_in = 4'b0000;
    expect_flit("t2", 2, 2'd1, 4'd7, 36'h50);
    tick(); expect_flit("t2", 3, 2'd1, 4'd7, 36'h50);
    check("t2_ready_after", msg_ready, 1'b1);
    tick(); check("t2_idle", flit_valid, 1'b0);
    check("t2_no_err", error, 1'b0);

    // Reset mid-packet after flit 2 of 4
    accept("t5", 4'd9, 2'd2, 36'h60);
    tick(); expect_flit("t5", 0, 2'd2, 4'd9, 36'h60);
    tick(); expect_flit("t5", 1, 2'd2, 4'd9, 36'h60);
    rst_n = 1'b0;
    #1;
    check("t5_rst_now", {flit_valid, flit_tail, msg_ready}, 3'b001);
    tick(); check("t5_rst_hold", flit_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    tick(); check("t5_rel_a", {flit_valid, flit_tail, msg_ready}, 3'b001);
    tick(); check("t5_rel_b", {flit_valid, flit_tail}, 2'b00);
    run_packet("t5_vc0a", 4'd1, 2'd0, 36'h70);
    run_packet("t5_vc0b", 4'd1, 2'd0, 36'h80);
    run_packet("t5_vc1", 4'd2, 2'd1, 36'h90);
    run_packet("t5_vc2", 4'd4, 2'd2, 36'hA0);

    // Overflow on VC3 (already at CREDITS): sticky error when built, counter saturates
    tick();
    check("t6_pre", error, 1'b0);
    credit_in = 4'b1000;
    tick();
    credit_in = 4'b0000;
    check("t6_err", error, ERR_EXP);
    tick(); tick();
    check("t6_err_hold", error, ERR_EXP);
    run_packet("t6_vc3a", 4'd8, 2'd3, 36'hB0);
    run_packet("t6_vc3b", 4'd8, 2'd3, 36'hC0);
    accept("t6_sat", 4'd8, 2'd3, 36'hD0);
    tick(); check("t6_sat_a", flit_valid, 1'b0);
    tick(); check("t6_sat_b", flit_valid, 1'b0);
    tick(); check("t6_sat_c", flit_valid, 1'b0);
    check("t6_err_final", error, ERR_EXP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
